// File: rtl/hnf_rxrsp_lcrd_ctrl_if.sv
// RXRSP link-layer signal bundle between the RN-facing link and the HNF credit controller.
// The design side uses the slave modport; the environment side uses master.
interface hnf_rxrsp_lcrd_ctrl_if;
    logic       RXLINKACTIVEREQ;
    logic       RXLINKACTIVEACK;
    logic       RXRSPFLITV;
    logic [5:0] rxrsp_opcode;
    logic       RXRSPLCRDV;
    logic       posq_push;
    logic       posq_pop;
    logic [3:0] lcrd_outstanding;
    logic [3:0] posq_occ;
    logic       err_no_credit;

    modport slave (
        input  RXLINKACTIVEREQ,
        input  RXRSPFLITV,
        input  rxrsp_opcode,
        input  posq_pop,
        output RXLINKACTIVEACK,
        output RXRSPLCRDV,
        output posq_push,
        output lcrd_outstanding,
        output posq_occ,
        output err_no_credit
    );

    modport master (
        output RXLINKACTIVEREQ,
        output RXRSPFLITV,
        output rxrsp_opcode,
        output posq_pop,
        input  RXLINKACTIVEACK,
        input  RXRSPLCRDV,
        input  posq_push,
        input  lcrd_outstanding,
        input  posq_occ,
        input  err_no_credit
    );
endinterface

// File: rtl/hnf_rxrsp_lcrd_ctrl.sv
// HNF RXRSP L-credit controller: link activation FSM, credit grant/consume accounting and
// posq occupancy tracking so that granted credits plus queued entries never exceed DEPTH.
module hnf_rxrsp_lcrd_ctrl #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_LCRD = 15
) (
    input  logic                 clock,
    input  logic                 reset,
    hnf_rxrsp_lcrd_ctrl_if.slave rx
);

    localparam logic [4:0] DepthW   = 5'(DEPTH);
    localparam logic [4:0] MaxLcrdW = 5'(MAX_LCRD);

    typedef enum logic [1:0] {
        StStop,
        StActivate,
        StRun,
        StDeactivate
    } link_state_e;

    link_state_e state_q, state_d;
    logic        ack_q, ack_d;
    logic        lcrdv_q, lcrdv_d;
    logic [3:0]  lcrd_q, lcrd_d;
    logic [3:0]  occ_q, occ_d;
    logic        err_q, err_d;

    logic [4:0]  free;
    logic        grant;
    logic        consume;
    logic        push;
    logic        pop_ok;

    // lcrd + occ never exceeds DEPTH, so this cannot go negative.
    assign free    = DepthW - {1'b0, occ_q} - {1'b0, lcrd_q};
    assign grant   = (state_q == StRun) && (free != 5'd0) && ({1'b0, lcrd_q} < MaxLcrdW);
    assign consume = rx.RXRSPFLITV && (lcrd_q != 4'd0);
    // LCrdReturn (opcode 0) only hands a credit back; it carries nothing for the posq.
    assign push    = consume && (rx.rxrsp_opcode != 6'h00) && reset;
    assign pop_ok  = rx.posq_pop && (occ_q != 4'd0);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StStop:       if (rx.RXLINKACTIVEREQ) state_d = StActivate;
            StActivate:   state_d = rx.RXLINKACTIVEREQ ? StRun : StStop;
            StRun:        if (!rx.RXLINKACTIVEREQ) state_d = StDeactivate;
            StDeactivate: if (lcrd_q == 4'd0) state_d = StStop;
            default:      state_d = StStop;
        endcase
        ack_d = (state_d == StRun) || (state_d == StDeactivate);
    end

    always_comb begin
        lcrdv_d = grant;
        lcrd_d  = lcrd_q;
        if (grant && !consume) begin
            lcrd_d = lcrd_q + 4'd1;
        end else if (!grant && consume) begin
            lcrd_d = lcrd_q - 4'd1;
        end
        occ_d = occ_q;
        if (push && !pop_ok) begin
            occ_d = occ_q + 4'd1;
        end else if (!push && pop_ok) begin
            occ_d = occ_q - 4'd1;
        end
        err_d = err_q || (rx.RXRSPFLITV && (lcrd_q == 4'd0));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StStop;
            ack_q   <= 1'b0;
            lcrdv_q <= 1'b0;
            lcrd_q  <= 4'd0;
            occ_q   <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            lcrdv_q <= lcrdv_d;
            lcrd_q  <= lcrd_d;
            occ_q   <= occ_d;
            err_q   <= err_d;
        end
    end

    assign rx.RXLINKACTIVEACK  = ack_q;
    assign rx.RXRSPLCRDV       = lcrdv_q;
    assign rx.posq_push        = push;
    assign rx.lcrd_outstanding = lcrd_q;
    assign rx.posq_occ         = occ_q;
    assign rx.err_no_credit    = err_q;

endmodule

// File: tb/tb_hnf_rxrsp_lcrd_ctrl.sv
// Bench for hnf_rxrsp_lcrd_ctrl: directed per-cycle vectors feed an expectation queue that an
// independent monitor drains and compares against the DUT outputs.
module tb_hnf_rxrsp_lcrd_ctrl;

    logic clock = 1'b0;
    logic reset = 1'b0;

    hnf_rxrsp_lcrd_ctrl_if bus ();

    hnf_rxrsp_lcrd_ctrl #(
        .DEPTH    (4),
        .MAX_LCRD (15)
    ) dut (
        .clock (clock),
        .reset (reset),
        .rx    (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        string      tag;
        logic       ack;
        logic       lcrdv;
        logic [3:0] lcrd;
        logic [3:0] occ;
        logic       push;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Drive one cycle of inputs at the falling edge and queue what the outputs must show
    // before the next rising edge.
    task automatic step(input string tag, input logic req, input logic flitv,
                        input logic [5:0] opc, input logic pop,
                        input logic e_ack, input logic e_lcrdv, input logic [3:0] e_lcrd,
                        input logic [3:0] e_occ, input logic e_push, input logic e_err);
        exp_t e;
        @(negedge clock);
        bus.RXLINKACTIVEREQ = req;
        bus.RXRSPFLITV      = flitv;
        bus.rxrsp_opcode    = opc;
        bus.posq_pop        = pop;
        e.tag   = tag;
        e.ack   = e_ack;
        e.lcrdv = e_lcrdv;
        e.lcrd  = e_lcrd;
        e.occ   = e_occ;
        e.push  = e_push;
        e.err   = e_err;
        exp_q.push_back(e);
    endtask

    task automatic check_reset(input string tag);
        total++;
        if (bus.RXLINKACTIVEACK !== 1'b0 || bus.RXRSPLCRDV !== 1'b0 ||
            bus.lcrd_outstanding !== 4'd0 || bus.posq_occ !== 4'd0 ||
            bus.posq_push !== 1'b0 || bus.err_no_credit !== 1'b0) begin
            bad++;
            $display("FAIL %s: got ack=%0b lcrdv=%0b lcrd=%0d occ=%0d push=%0b err=%0b, want all 0",
                     tag, bus.RXLINKACTIVEACK, bus.RXRSPLCRDV, bus.lcrd_outstanding,
                     bus.posq_occ, bus.posq_push, bus.err_no_credit);
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clock);
        #3;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s: %0d expectations left unchecked, want 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                total++;
                if (bus.RXLINKACTIVEACK !== e.ack || bus.RXRSPLCRDV !== e.lcrdv ||
                    bus.lcrd_outstanding !== e.lcrd || bus.posq_occ !== e.occ ||
                    bus.posq_push !== e.push || bus.err_no_credit !== e.err) begin
                    bad++;
                    $display("FAIL %s: got ack=%0b lcrdv=%0b lcrd=%0d occ=%0d push=%0b err=%0b, want ack=%0b lcrdv=%0b lcrd=%0d occ=%0d push=%0b err=%0b",
                             e.tag, bus.RXLINKACTIVEACK, bus.RXRSPLCRDV, bus.lcrd_outstanding,
                             bus.posq_occ, bus.posq_push, bus.err_no_credit,
                             e.ack, e.lcrdv, e.lcrd, e.occ, e.push, e.err);
                end
            end
        end
    end

    initial begin : stim
        bus.RXLINKACTIVEREQ = 1'b1;
        bus.RXRSPFLITV      = 1'b1;
        bus.rxrsp_opcode    = 6'h14;
        bus.posq_pop        = 1'b1;
        repeat (2) @(negedge clock);
        #2;
        check_reset("por");
        @(negedge clock);
        bus.RXLINKACTIVEREQ = 1'b0;
        bus.RXRSPFLITV      = 1'b0;
        bus.rxrsp_opcode    = 6'h00;
        bus.posq_pop        = 1'b0;
        reset = 1'b1;

        // Activation and initial credit burst (DEPTH=4)
        step("act0",  1, 0, 6'h00, 0,  0, 0, 0, 0, 0, 0);
        step("act1",  1, 0, 6'h00, 0,  0, 0, 0, 0, 0, 0);
        step("run",   1, 0, 6'h00, 0,  1, 0, 0, 0, 0, 0);
        step("g1",    1, 0, 6'h00, 0,  1, 1, 1, 0, 0, 0);
        step("g2",    1, 0, 6'h00, 0,  1, 1, 2, 0, 0, 0);
        step("g3",    1, 0, 6'h00, 0,  1, 1, 3, 0, 0, 0);
        step("g4",    1, 0, 6'h00, 0,  1, 1, 4, 0, 0, 0);
        step("full0", 1, 0, 6'h00, 0,  1, 0, 4, 0, 0, 0);
        step("full1", 1, 0, 6'h00, 0,  1, 0, 4, 0, 0, 0);
        // Four data flits fill the posq, then one pop earns one credit
        step("f1",    1, 1, 6'h14, 0,  1, 0, 4, 0, 1, 0);
        step("f2",    1, 1, 6'h01, 0,  1, 0, 3, 1, 1, 0);
        step("f3",    1, 1, 6'h3f, 0,  1, 0, 2, 2, 1, 0);
        step("f4",    1, 1, 6'h05, 0,  1, 0, 1, 3, 1, 0);
        step("q4",    1, 0, 6'h00, 0,  1, 0, 0, 4, 0, 0);
        step("pop1",  1, 0, 6'h00, 1,  1, 0, 0, 4, 0, 0);
        step("pw0",   1, 0, 6'h00, 0,  1, 0, 0, 3, 0, 0);
        step("pg",    1, 0, 6'h00, 0,  1, 1, 1, 3, 0, 0);
        step("pw1",   1, 0, 6'h00, 0,  1, 0, 1, 3, 0, 0);
        // Drain the posq to build up credits for streaming
        step("r0",    1, 0, 6'h00, 1,  1, 0, 1, 3, 0, 0);
        step("r1",    1, 0, 6'h00, 1,  1, 0, 1, 2, 0, 0);
        step("r2",    1, 0, 6'h00, 0,  1, 1, 2, 1, 0, 0);
        step("r3",    1, 0, 6'h00, 0,  1, 1, 3, 1, 0, 0);
        // Flit plus pop every cycle settles to one grant per cycle
        step("s0",    1, 1, 6'h02, 1,  1, 0, 3, 1, 1, 0);
        step("s1",    1, 1, 6'h03, 1,  1, 0, 2, 1, 1, 0);
        step("s2",    1, 1, 6'h04, 1,  1, 1, 2, 1, 1, 0);
        step("s3",    1, 1, 6'h05, 1,  1, 1, 2, 1, 1, 0);
        step("s4",    1, 1, 6'h06, 1,  1, 1, 2, 1, 1, 0);
        step("s5",    1, 0, 6'h00, 0,  1, 1, 2, 1, 0, 0);
        step("s6",    1, 0, 6'h00, 0,  1, 1, 3, 1, 0, 0);
        // Deactivation with 3 credits out; pop frees space but no grants follow
        step("d0",    0, 0, 6'h00, 0,  1, 0, 3, 1, 0, 0);
        step("d1",    0, 0, 6'h00, 1,  1, 0, 3, 1, 0, 0);
        step("d2",    0, 1, 6'h00, 0,  1, 0, 3, 0, 0, 0);
        step("d3",    1, 1, 6'h00, 0,  1, 0, 2, 0, 0, 0);
        step("d4",    0, 1, 6'h00, 0,  1, 0, 1, 0, 0, 0);
        step("d5",    0, 0, 6'h00, 0,  1, 0, 0, 0, 0, 0);
        step("stop",  0, 0, 6'h00, 0,  0, 0, 0, 0, 0, 0);
        // Flit with no credit in STOP
        step("e0",    0, 1, 6'h14, 0,  0, 0, 0, 0, 0, 0);
        step("e1",    0, 0, 6'h00, 0,  0, 0, 0, 0, 0, 1);
        // Back to RUN with 2 credits and 2 posq entries; error stays sticky
        step("b0",    1, 0, 6'h00, 0,  0, 0, 0, 0, 0, 1);
        step("b1",    1, 0, 6'h00, 0,  0, 0, 0, 0, 0, 1);
        step("b2",    1, 0, 6'h00, 0,  1, 0, 0, 0, 0, 1);
        step("b3",    1, 0, 6'h00, 0,  1, 1, 1, 0, 0, 1);
        step("b4",    1, 1, 6'h11, 0,  1, 1, 2, 0, 1, 1);
        step("b5",    1, 1, 6'h12, 0,  1, 1, 2, 1, 1, 1);
        step("b6",    1, 0, 6'h00, 0,  1, 1, 2, 2, 0, 1);
        step("b7",    1, 0, 6'h00, 0,  1, 0, 2, 2, 0, 1);
        drain("drain_run");

        // Asynchronous reset between clock edges, with a flit still presented
        @(negedge clock);
        #3;
        bus.RXRSPFLITV   = 1'b1;
        bus.rxrsp_opcode = 6'h14;
        reset = 1'b0;
        #1;
        check_reset("async_rst");
        repeat (2) @(negedge clock);
        #2;
        check_reset("rst_hold");
        @(negedge clock);
        bus.RXRSPFLITV   = 1'b0;
        bus.rxrsp_opcode = 6'h00;
        bus.RXLINKACTIVEREQ = 1'b0;
        reset = 1'b1;

        // REQ withdrawn during ACTIVATE falls back to STOP
        step("w0",    1, 0, 6'h00, 0,  0, 0, 0, 0, 0, 0);
        step("w1",    0, 0, 6'h00, 0,  0, 0, 0, 0, 0, 0);
        step("w2",    0, 0, 6'h00, 0,  0, 0, 0, 0, 0, 0);
        step("w3",    0, 0, 6'h00, 0,  0, 0, 0, 0, 0, 0);
        drain("drain_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
